ahb_lite_req_master: RTL

AHB_LITE_REQ_MASTER -- requirements
Module: ahb_lite_req_master

---
 rtl/ahb_lite_req_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_req_master.sv
// AHB-Lite single-transfer master fed by a small request FIFO.
// One address phase then one data phase per request, never pipelined.
module ahb_lite_req_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic              HSEL,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] f_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] f_wdata [FIFO_DEPTH];
  logic              f_write [FIFO_DEPTH];
  logic [2:0]        f_size  [FIFO_DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              done;
  logic [2:0]        head_size;
  logic [DATA_W-1:0] cmd_wdata;

  // Sizes above word are issued as word transfers.
  function automatic logic [2:0] clamp(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  // Force the address onto the natural boundary of the transfer size.
  function automatic logic [ADDR_W-1:0] align(
    input logic [ADDR_W-1:0] a,
    input logic [2:0]        s
  );
    logic [ADDR_W-1:0] r;
    r = a;
    if (s == 3'd1) begin
      r[0] = 1'b0;
    end else if (s == 3'd2) begin
      r[1:0] = 2'b00;
    end
    return r;
  endfunction

  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign head_size = clamp(f_size[rd_ptr]);
  assign done      = (state == DATA) && HREADY;
  assign busy      = (state != IDLE) || (count != '0);

  assign HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  assign HSEL      = (state == ADDR);
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  // FIFO storage; contents only matter between the pointers.
  always_ff @(posedge HCLK) begin
    if (push) begin
      f_addr[wr_ptr]  <= req_addr;
      f_wdata[wr_ptr] <= req_wdata;
      f_write[wr_ptr] <= req_write;
      f_size[wr_ptr]  <= req_size;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; a pop loads the command register on the IDLE exit.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (HREADY) state_n = DATA;
      end
      DATA: begin
        if (HREADY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command register drives the address phase and holds between transfers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      cmd_wdata <= '0;
    end else if (pop) begin
      HADDR     <= align(f_addr[rd_ptr], head_size);
      HWRITE    <= f_write[rd_ptr];
      HSIZE     <= head_size;
      cmd_wdata <= f_wdata[rd_ptr];
    end
  end

  // Write data is presented from the start of the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HWDATA <= '0;
    end else if ((state == ADDR) && HREADY) begin
      HWDATA <= cmd_wdata;
    end
  end

  // One-cycle completion pulse carrying the slave response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err   <= HRESP;
        rsp_rdata <= HWRITE ? '0 : HRDATA;
      end
    end
  end

endmodule
